cc_enc_arb: RTL and testbench

CC_ENC_ARB -- requirements
Module: cc_enc_arb

---
 rtl/cc_enc_arb.sv | 172 +++++++++++++++++
 tb/tb_cc_enc_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_enc_arb.sv
// Round-robin arbiter sharing one serial (7,4) cyclic encoder among NREQ requesters,
// with frame-timing supervision. Optional statistics: define CC_ENC_ARB_STATS_EN.
//
// state | meaning
// HUNT  | unlocked; any enc_ready starts a frame and locks
// RUN   | locked; enc_ready expected exactly when the frame timer hits terminal count
module cc_enc_arb #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              enc_ready,
    output logic [3:0]        enc_code_in,
    input  logic              enc_code_out,
    output logic              ser_valid,
    output logic              ser_data,
    output logic              ser_sof,
    output logic [IDW-1:0]    ser_owner,
    output logic              ser_idle,
    output logic              sync_err
`ifdef CC_ENC_ARB_STATS_EN
    ,
    output logic [8*NREQ-1:0] frm_cnt,
    output logic [7:0]        idle_cnt
`endif
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [2:0]     frm_tmr, frm_tmr_nxt;
    logic           err_set;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           grant;
    logic           start;

    logic           bit_act;
    logic [2:0]     bit_idx;
    logic [IDW-1:0] pend_owner;
    logic           pend_idle;

    // Every strobe opens a frame; the FSM only judges whether it was on time.
    assign start = enc_ready && !reset;

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!grant && req_valid[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        req_ready   = '0;
        enc_code_in = 4'b0000;
        if (start && grant) begin
            req_ready[winner] = 1'b1;
            enc_code_in       = req_data[{winner, 2'b00} +: 4];
        end
    end

    always_comb begin
        state_nxt   = state;
        err_set     = 1'b0;
        frm_tmr_nxt = (frm_tmr != 3'd0) ? frm_tmr - 3'd1 : frm_tmr;
        if (start) begin
            frm_tmr_nxt = 3'd6;
        end
        case (state)
            HUNT: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    // A misplaced strobe still opens a frame and keeps the lock.
                    if (frm_tmr != 3'd0) begin
                        err_set = 1'b1;
                    end
                end else if (frm_tmr == 3'd0) begin
                    err_set   = 1'b1;
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            frm_tmr  <= 3'd0;
            sync_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            frm_tmr <= frm_tmr_nxt;
            if (err_set) begin
                sync_err <= 1'b1;
            end
        end
    end

    // Owner/idle tags wait in pend_* until bit 0 is presented, so they flip together
    // with ser_sof and the last bit of the previous frame keeps its own tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            pend_owner <= '0;
            pend_idle  <= 1'b1;
            bit_act    <= 1'b0;
            bit_idx    <= 3'd0;
            ser_valid  <= 1'b0;
            ser_data   <= 1'b0;
            ser_sof    <= 1'b0;
            ser_owner  <= '0;
            ser_idle   <= 1'b1;
        end else begin
            ser_valid <= bit_act;
            ser_data  <= bit_act && enc_code_out;
            ser_sof   <= bit_act && (bit_idx == 3'd0);
            if (bit_act && (bit_idx == 3'd0)) begin
                ser_owner <= pend_owner;
                ser_idle  <= pend_idle;
            end
            if (start) begin
                bit_act   <= 1'b1;
                bit_idx   <= 3'd0;
                pend_idle <= !grant;
                if (grant) begin
                    pend_owner <= winner;
                    rr_ptr     <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end else if (bit_act) begin
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd6) begin
                    bit_act <= 1'b0;
                end
            end
        end
    end

`ifdef CC_ENC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frm_cnt  <= '0;
            idle_cnt <= 8'd0;
        end else if (start) begin
            if (grant) begin
                if (frm_cnt[{winner, 3'b000} +: 8] != 8'hFF) begin
                    frm_cnt[{winner, 3'b000} +: 8] <= frm_cnt[{winner, 3'b000} +: 8] + 8'd1;
                end
            end else if (idle_cnt != 8'hFF) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cc_enc_arb.sv
// Scoreboard bench for cc_enc_arb: directed frames, serial output checked by a monitor.
// Statistics checks are compiled in when CC_ENC_ARB_STATS_EN is defined.
module tb_cc_enc_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              enc_ready;
    logic [3:0]        enc_code_in;
    logic              enc_code_out;
    logic              ser_valid;
    logic              ser_data;
    logic              ser_sof;
    logic [IDW-1:0]    ser_owner;
    logic              ser_idle;
    logic              sync_err;
`ifdef CC_ENC_ARB_STATS_EN
    logic [8*NREQ-1:0] frm_cnt;
    logic [7:0]        idle_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cc_enc_arb #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .enc_ready   (enc_ready),
        .enc_code_in (enc_code_in),
        .enc_code_out(enc_code_out),
        .ser_valid   (ser_valid),
        .ser_data    (ser_data),
        .ser_sof     (ser_sof),
        .ser_owner   (ser_owner),
        .ser_idle    (ser_idle),
        .sync_err    (sync_err)
`ifdef CC_ENC_ARB_STATS_EN
        ,
        .frm_cnt     (frm_cnt),
        .idle_cnt    (idle_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Systematic cyclic code, g(x) = x^3 + x + 1, codeword {m, parity}.
    function automatic logic [6:0] cc_encode(input logic [3:0] m);
        logic [6:0] r;
        logic [6:0] g;
        r = {m, 3'b000};
        g = 7'b1011000;
        for (int i = 0; i < 4; i++) begin
            if ((r & (7'b1000000 >> i)) != 7'd0) r = r ^ g;
            g = g >> 1;
        end
        return {m, r[2:0]};
    endfunction

    // Encoder model: latches the message on the strobe, emits bit k in cycle T+1+k.
    logic [6:0] enc_cw  = 7'd0;
    logic [2:0] enc_k   = 3'd0;
    logic       enc_act = 1'b0;
    always @(posedge clk) begin
        if (enc_ready) begin
            enc_cw  <= cc_encode(enc_code_in);
            enc_k   <= 3'd0;
            enc_act <= 1'b1;
        end else if (enc_act) begin
            enc_k <= enc_k + 3'd1;
            if (enc_k == 3'd6) enc_act <= 1'b0;
        end
    end
    assign enc_code_out = enc_act ? enc_cw[enc_k] : 1'b0;

    typedef struct {
        logic [IDW-1:0] owner;
        logic           idle;
        logic [6:0]     cw;
        int             nbits;
    } frm_t;

    frm_t exp_q[$];
    frm_t cur;
    bit   cur_act = 1'b0;
    int   bidx    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (ser_valid) begin
            if (ser_sof) begin
                if (cur_act) chk("frame_len", 32'(bidx), 32'(cur.nbits));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: sof with empty scoreboard (t=%0t)", $time);
                    cur_act = 1'b0;
                end else begin
                    cur     = exp_q.pop_front();
                    cur_act = 1'b1;
                    bidx    = 0;
                end
            end
            if (!cur_act) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_bit: ser_valid outside expected frame (t=%0t)", $time);
            end else begin
                chk("ser_bit {data,owner,idle}", {ser_data, ser_owner, ser_idle},
                    {cur.cw[3'(bidx)], cur.owner, cur.idle});
                bidx++;
                if (bidx == cur.nbits) cur_act = 1'b0;
            end
        end
    end

    task automatic start_frame(input logic [3:0] gnt, input logic [3:0] code,
                               input int owner, input logic idle, input int nbits);
        frm_t f;
        enc_ready = 1'b1;
        #1;
        chk("req_ready_at_T", 32'(req_ready), 32'(gnt));
        chk("enc_code_in_at_T", 32'(enc_code_in), 32'(code));
        f.owner = IDW'(owner);
        f.idle  = idle;
        f.cw    = cc_encode(code);
        f.nbits = nbits;
        exp_q.push_back(f);
        @(negedge clk);
        enc_ready = 1'b0;
    endtask

    task automatic cyc_chk(input int n, input int sof_at);
        for (int j = 1; j <= n; j++) begin
            #1;
            chk("req_ready_idle", 32'(req_ready), 32'd0);
            if (j == sof_at) chk("ser_sof_at_T2", 32'(ser_sof), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic frame(input logic [3:0] gnt, input logic [3:0] code,
                         input int owner, input logic idle);
        start_frame(gnt, code, owner, idle, 7);
        cyc_chk(6, 2);
    endtask

    task automatic check_reset_vals();
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_ser_data", 32'(ser_data), 32'd0);
        chk("rst_ser_sof", 32'(ser_sof), 32'd0);
        chk("rst_ser_owner", 32'(ser_owner), 32'd0);
        chk("rst_ser_idle", 32'(ser_idle), 32'd1);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_enc_code_in", 32'(enc_code_in), 32'd0);
`ifdef CC_ENC_ARB_STATS_EN
        chk("rst_frm_cnt", frm_cnt, 32'd0);
        chk("rst_idle_cnt", 32'(idle_cnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        enc_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // All four requesters valid: fair rotation 0,1,2,3,0.
        req_valid = 4'b1111;
        req_data  = {4'hE, 4'h3, 4'hA, 4'h5};
        frame(4'b0001, 4'h5, 0, 1'b0);
        frame(4'b0010, 4'hA, 1, 1'b0);
        frame(4'b0100, 4'h3, 2, 1'b0);
        frame(4'b1000, 4'hE, 3, 1'b0);
        frame(4'b0001, 4'h5, 0, 1'b0);

        // No requests: filler frames keep the last owner tag.
        req_valid = 4'b0000;
        repeat (3) frame(4'b0000, 4'h0, 0, 1'b1);

        // Single requester 0 with 1011; pointer sits at 1 and wraps.
        req_valid = 4'b0001;
        req_data  = {4'hE, 4'h3, 4'hA, 4'hB};
        frame(4'b0001, 4'b1011, 0, 1'b0);

        // Sparse requesters 1 and 3.
        req_valid = 4'b1010;
        frame(4'b0010, 4'hA, 1, 1'b0);
        frame(4'b1000, 4'hE, 3, 1'b0);
        frame(4'b0010, 4'hA, 1, 1'b0);
        chk("sync_err_clean_cadence", 32'(sync_err), 32'd0);

        // Reset while frame bit 3 is on ser_data.
        start_frame(4'b1000, 4'hE, 3, 1'b0, 4);
        cyc_chk(4, 2);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("no_valid_after_reset", 32'(ser_valid), 32'd0);
            @(negedge clk);
        end

        // Strobes at relative cycles 0, 7, 12, 19: the one at 12 is misplaced.
        req_valid = 4'b0100;
        req_data  = {4'hE, 4'h9, 4'hA, 4'hB};
        frame(4'b0100, 4'h9, 2, 1'b0);
        start_frame(4'b0100, 4'h9, 2, 1'b0, 5);
        cyc_chk(4, 2);
        chk("sync_err_before_misplaced", 32'(sync_err), 32'd0);
        start_frame(4'b0100, 4'h9, 2, 1'b0, 7);
        #1;
        chk("sync_err_after_misplaced", 32'(sync_err), 32'd1);
        cyc_chk(6, 2);
        frame(4'b0100, 4'h9, 2, 1'b0);
        cyc_chk(6, 0);

        // Missing strobe at the expected frame start.
        do_reset();
        frame(4'b0100, 4'h9, 2, 1'b0);
        chk("sync_err_at_missing_start", 32'(sync_err), 32'd0);
        @(negedge clk);
        #1;
        chk("sync_err_after_missing", 32'(sync_err), 32'd1);
        repeat (2) @(negedge clk);
        frame(4'b0100, 4'h9, 2, 1'b0);
        chk("sync_err_sticky", 32'(sync_err), 32'd1);
        cyc_chk(4, 0);

`ifdef CC_ENC_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) frame(4'b0100, 4'h9, 2, 1'b0);
        chk("frm_cnt_req2_saturated", 32'(frm_cnt[23:16]), 32'd255);
        chk("frm_cnt_req0", 32'(frm_cnt[7:0]), 32'd0);
        chk("idle_cnt_none", 32'(idle_cnt), 32'd0);
        req_valid = 4'b0000;
        frame(4'b0000, 4'h0, 2, 1'b1);
        chk("idle_cnt_one", 32'(idle_cnt), 32'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() != 0 || cur_act) @(negedge clk);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("last_frame_complete", 32'(cur_act), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
